// File: rtl/mlp_step_engine.sv
// mlp_step_engine
// Time-multiplexed step-detection network: N_IN signed inputs feed N_HID
// hidden nodes, whose results feed one output node followed by a threshold
// activation. A single shared MAC is sequenced by the FSM below; weights are
// loaded at runtime through a write port that is open only while idle.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   wt_we      weight write strobe
//   wt_addr    weight address (hidden h / input i at h*N_IN+i,
//              output weight h at N_HID*N_IN+h)
//   wt_data    signed weight
//   wt_ready   high only in IDLE; writes taken only when high
//   in_valid   sample valid
//   in_ready   high only in IDLE
//   in_data    input i at bits [i*W +: W], signed
//   out_valid  result valid
//   out_ready  consumer accepts result
//   score      signed output-node result
//   step       score >= THRESH
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a sample; weight writes accepted
// HID    | one MAC per cycle over hidden nodes (node-major, input-minor)
// OUT    | one MAC per cycle over hidden registers for the output node
// ACT    | register score/step, commit any deferred weight write
// DONE   | result presented until out_ready
module mlp_step_engine #(
    parameter int W        = 8,
    parameter int N_IN     = 2,
    parameter int N_HID    = 2,
    parameter int WA       = 3,
    parameter int ACC_W    = 20,
    parameter int FRAC     = 4,
    parameter int THRESH   = 0,
    parameter int HID_RELU = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wt_we,
    input  logic [WA-1:0]     wt_addr,
    input  logic [W-1:0]      wt_data,
    output logic              wt_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN*W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      score,
    output logic              step
);

    localparam int NW = N_HID * (N_IN + 1);
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (W - 1)));
    localparam logic signed [W-1:0]     THRESH_W = W'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID,
        S_OUT,
        S_ACT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] wt_mem [NW];
    logic signed [W-1:0] x_q    [N_IN];
    logic signed [W-1:0] hid_q  [N_HID];

    logic [HW-1:0]           h_cnt;
    logic [IW-1:0]           i_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [W-1:0]     out_r;
    logic signed [W-1:0]     score_q;
    logic                    step_q;

    // A write that lands in the same cycle as a sample handshake is parked
    // here so the sample still sees the old word; it is committed once the
    // MAC has finished reading weights.
    logic                pend_v;
    logic [WA-1:0]       pend_addr;
    logic signed [W-1:0] pend_data;

    logic                    last_in, last_hid, first, wt_in_range;
    logic [WA-1:0]           wt_idx;
    logic signed [W-1:0]     mac_a, mac_b;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext, acc_base, mac_sum, shifted;
    logic signed [W-1:0]     mac_sat, hid_res;

    assign last_in     = (int'(i_cnt) == N_IN - 1);
    assign last_hid    = (int'(h_cnt) == N_HID - 1);
    assign wt_in_range = (int'(wt_addr) < NW);

    // Operand select and shared MAC datapath
    always_comb begin
        wt_idx = '0;
        mac_a  = '0;
        first  = 1'b0;
        if (state == S_OUT) begin
            wt_idx = WA'(N_HID * N_IN + int'(h_cnt));
            mac_a  = hid_q[h_cnt];
            first  = (h_cnt == '0);
        end else begin
            wt_idx = WA'(int'(h_cnt) * N_IN + int'(i_cnt));
            mac_a  = x_q[i_cnt];
            first  = (i_cnt == '0);
        end
        mac_b    = wt_mem[wt_idx];
        prod     = mac_a * mac_b;
        prod_ext = {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
        acc_base = first ? '0 : acc;
        mac_sum  = acc_base + prod_ext;
        shifted  = mac_sum >>> FRAC;
        if (shifted > SAT_MAX) begin
            mac_sat = SAT_MAX[W-1:0];
        end else if (shifted < SAT_MIN) begin
            mac_sat = SAT_MIN[W-1:0];
        end else begin
            mac_sat = shifted[W-1:0];
        end
        hid_res = ((HID_RELU != 0) && mac_sat[W-1]) ? '0 : mac_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_HID;
            S_HID:   if (last_in && last_hid) state_nxt = S_OUT;
            S_OUT:   if (last_hid) state_nxt = S_ACT;
            S_ACT:   state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt     <= '0;
            i_cnt     <= '0;
            acc       <= '0;
            out_r     <= '0;
            score_q   <= '0;
            step_q    <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            for (int k = 0; k < NW; k++)    wt_mem[k] <= '0;
            for (int k = 0; k < N_IN; k++)  x_q[k]    <= '0;
            for (int k = 0; k < N_HID; k++) hid_q[k]  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    h_cnt <= '0;
                    i_cnt <= '0;
                    if (in_valid) begin
                        for (int k = 0; k < N_IN; k++) x_q[k] <= in_data[k*W +: W];
                    end
                    if (wt_we && wt_in_range) begin
                        if (in_valid) begin
                            pend_v    <= 1'b1;
                            pend_addr <= wt_addr;
                            pend_data <= wt_data;
                        end else begin
                            wt_mem[wt_addr] <= wt_data;
                        end
                    end
                end
                S_HID: begin
                    acc <= mac_sum;
                    if (last_in) begin
                        hid_q[h_cnt] <= hid_res;
                        i_cnt        <= '0;
                        h_cnt        <= last_hid ? '0 : h_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    acc <= mac_sum;
                    if (last_hid) begin
                        out_r <= mac_sat;
                        h_cnt <= '0;
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                S_ACT: begin
                    score_q <= out_r;
                    step_q  <= (out_r >= THRESH_W);
                    if (pend_v) begin
                        wt_mem[pend_addr] <= pend_data;
                        pend_v            <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wt_ready  = (state == S_IDLE);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign score     = score_q;
    assign step      = step_q;

endmodule

// File: tb/tb_mlp_step_engine.sv
module tb_mlp_step_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        wt_we;
    logic [2:0]  wt_addr;
    logic [7:0]  wt_data;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        wt_ready, in_ready, out_valid, step;
    logic [7:0]  score;
    logic        wt_ready_r, in_ready_r, out_valid_r, step_r;
    logic [7:0]  score_r;

    int checks = 0;
    int errors = 0;

    mlp_step_engine u_dut (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_ready(wt_ready), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .score(score), .step(step)
    );

    mlp_step_engine #(.HID_RELU(1)) u_relu (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_ready(wt_ready_r), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .score(score_r), .step(step_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_wt(input logic [2:0] a, input logic [7:0] d);
        wt_we = 1'b1; wt_addr = a; wt_data = d;
        tick();
        wt_we = 1'b0;
    endtask

    task automatic set_all_weights(input logic [7:0] d);
        for (int k = 0; k < 6; k++) write_wt(3'(k), d);
    endtask

    // Handshake one sample, then scramble in_data to show it is not re-read.
    task automatic start_sample(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        in_valid = 1'b1; in_data = {b, a};
        tick();
        in_valid = 1'b0; in_data = 16'hA5A5;
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        lat = out_valid ? n : -1;
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output logic [7:0] sc, output logic st,
                       output logic [7:0] sc_r, output logic st_r);
        start_sample(a, b);
        wait_valid(lat);
        sc = score; st = step; sc_r = score_r; st_r = step_r;
        pop_result();
    endtask

    task automatic test_reset();
        int lat; logic [7:0] sc, scr; logic st, str;
        rst = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (score !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", score); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || wt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got in=%b wt=%b want 1 1", in_ready, wt_ready); end
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'h00 || st !== 1'b1) begin errors++; $display("FAIL reset_zero_wt got score=%h step=%b want 00 1", sc, st); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] sc, scr; logic st, str;
        set_all_weights(8'd16);
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
        checks++; if (sc !== 8'd60 || st !== 1'b1) begin errors++; $display("FAIL basic_score got %h/%b want 3c/1", sc, st); end
        checks++; if (scr !== 8'd60 || str !== 1'b1) begin errors++; $display("FAIL basic_relu got %h/%b want 3c/1", scr, str); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_pop got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_negative();
        int lat; logic [7:0] sc, scr; logic st, str;
        run(8'hF6, 8'hEC, lat, sc, st, scr, str);
        checks++; if (sc !== 8'hC4 || st !== 1'b0) begin errors++; $display("FAIL neg_score got %h/%b want c4/0", sc, st); end
        checks++; if (scr !== 8'h00 || str !== 1'b1) begin errors++; $display("FAIL neg_relu got %h/%b want 00/1", scr, str); end
    endtask

    task automatic test_saturate();
        int lat; logic [7:0] sc, scr; logic st, str;
        set_all_weights(8'd127);
        run(8'd127, 8'd127, lat, sc, st, scr, str);
        checks++; if (sc !== 8'h7F || st !== 1'b1) begin errors++; $display("FAIL sat_pos got %h/%b want 7f/1", sc, st); end
        run(8'h80, 8'h80, lat, sc, st, scr, str);
        checks++; if (sc !== 8'h80 || st !== 1'b0) begin errors++; $display("FAIL sat_neg got %h/%b want 80/0", sc, st); end
        checks++; if (scr !== 8'h00 || str !== 1'b1) begin errors++; $display("FAIL sat_neg_relu got %h/%b want 00/1", scr, str); end
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] sc, scr; logic st, str;
        set_all_weights(8'd16);
        start_sample(8'd10, 8'd20);
        wait_valid(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL bp_latency got %0d want 7", lat); end
        in_valid = 1'b1; in_data = {8'd1, 8'd1};
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || score !== 8'd60 || step !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got ov=%b sc=%h st=%b ir=%b want 1 3c 1 0", c, out_valid, score, step, in_ready);
            end
        end
        in_valid = 1'b0;
        pop_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", out_valid, in_ready); end
        run(8'hF6, 8'hEC, lat, sc, st, scr, str);
        checks++; if (sc !== 8'hC4 || st !== 1'b0) begin errors++; $display("FAIL bp_next got %h/%b want c4/0", sc, st); end
    endtask

    task automatic test_weight_writes();
        int lat; logic [7:0] sc, scr; logic st, str;
        start_sample(8'd10, 8'd20);
        wt_we = 1'b1; wt_addr = 3'd0; wt_data = 8'hF0;
        tick();
        checks++; if (wt_ready !== 1'b0) begin errors++; $display("FAIL wt_ready_busy got %b want 0", wt_ready); end
        tick();
        wt_we = 1'b0;
        wait_valid(lat);
        sc = score; st = step;
        pop_result();
        checks++; if (sc !== 8'd60) begin errors++; $display("FAIL wt_busy_cur got %h want 3c", sc); end
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'd60) begin errors++; $display("FAIL wt_busy_next got %h want 3c", sc); end
        write_wt(3'd0, 8'hF0);
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'd40 || st !== 1'b1) begin errors++; $display("FAIL wt_idle got %h/%b want 28/1", sc, st); end
        write_wt(3'd7, 8'hF0);
        write_wt(3'd6, 8'hF0);
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'd40) begin errors++; $display("FAIL wt_out_of_range got %h want 28", sc); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] sc, scr; logic st, str;
        // Write addr 0 back to 16 in the same cycle as the handshake.
        wt_we = 1'b1; wt_addr = 3'd0; wt_data = 8'd16;
        in_valid = 1'b1; in_data = {8'd20, 8'd10};
        tick();
        wt_we = 1'b0; in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL b2b_latency got %0d want 7", lat); end
        sc = score;
        pop_result();
        checks++; if (sc !== 8'd40) begin errors++; $display("FAIL b2b_old_weight got %h want 28", sc); end
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'd60) begin errors++; $display("FAIL b2b_new_weight got %h want 3c", sc); end
    endtask

    task automatic test_mid_reset();
        int lat; int seen; logic [7:0] sc, scr; logic st, str;
        start_sample(8'd10, 8'd20);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state got ir=%b ov=%b want 1 0", in_ready, out_valid); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin tick(); if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_output got %0d valid cycles want 0", seen); end
        run(8'd10, 8'd20, lat, sc, st, scr, str);
        checks++; if (sc !== 8'h00 || st !== 1'b1) begin errors++; $display("FAIL midrst_cleared got %h/%b want 00/1", sc, st); end
    endtask

    initial begin
        rst = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_saturate();
        test_backpressure();
        test_weight_writes();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
